bus_arbiter: RTL and testbench

- Shares one valid/ready compute unit (16-bit A/B operands, 32-bit result) between NREQ requesters.
- Round-robin grant; latches the winner's operands and issues a one-cycle valid pulse to the unit.
- Waits for the unit's ready pulse, or a timeout, then returns the result to the granted requester.
- Sits between client masters and the shared unit; one transaction in flight at a time.

---
 rtl/bus_pkg.sv | 25 ++
 rtl/bus_arbiter_rr_picker.sv | 34 +++
 rtl/bus_arbiter.sv | 161 ++++++++++++++++
 tb/tb_bus_arbiter.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared definitions for the bus arbiter: FSM state encoding, datapath
// widths and the grant-id width helper.
package bus_pkg;

    localparam int OP_W  = 16;
    localparam int RES_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    // Bits needed to index n requesters; never less than one bit.
    function automatic int clog2(input int n);
        int w;
        w = 1;
        while ((32'sd1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/bus_arbiter_rr_picker.sv
// Combinational round-robin priority encoder: finds the first asserted
// request strictly after rr_ptr, wrapping modulo NREQ, so the last winner
// has the lowest priority on the next pick.
module rr_picker
    import bus_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int GW   = clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [GW-1:0]   rr_ptr,
    output logic [GW-1:0]   gnt_id,
    output logic            any
);

    logic [GW-1:0] idx_s;

    // Scan NREQ positions starting just after rr_ptr; first hit wins.
    always_comb begin
        gnt_id = '0;
        any    = 1'b0;
        idx_s  = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx_s = GW'((int'(rr_ptr) + k) % NREQ);
            if (!any && req[idx_s]) begin
                any    = 1'b1;
                gnt_id = idx_s;
            end else begin
                any    = any;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter sharing one valid/ready compute unit among NREQ
// requesters. One transaction in flight: grant, issue, wait (with timeout),
// respond, then re-arbitrate.
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 7
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*16-1:0]   req_a,
    input  logic [NREQ*16-1:0]   req_b,
    output logic [NREQ-1:0]      req_accept,
    output logic [NREQ-1:0]      rsp_valid,
    output logic [31:0]          rsp_result,
    output logic                 rsp_timeout,
    output logic [15:0]          unit_a,
    output logic [15:0]          unit_b,
    output logic                 unit_valid,
    input  logic                 unit_ready,
    input  logic [31:0]          unit_result,
    output logic                 busy
);

    localparam int GW = clog2(NREQ);

    state_t            state_r;
    state_t            state_s;
    logic [GW-1:0]     rr_ptr_r;
    logic [GW-1:0]     grant_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [OP_W-1:0]   a_r;
    logic [OP_W-1:0]   b_r;
    logic [RES_W-1:0]  result_r;
    logic              timeout_r;
    logic [GW-1:0]     pick_id_s;
    logic              pick_any_s;
    logic              expire_s;
    logic [NREQ-1:0]   grant_oh_s;

    rr_picker #(.NREQ(NREQ), .GW(GW)) u_picker (
        .req    (req_valid),
        .rr_ptr (rr_ptr_r),
        .gnt_id (pick_id_s),
        .any    (pick_any_s)
    );

    assign expire_s   = (cnt_r == CNT_W'(TIMEOUT - 1));
    assign grant_oh_s = {{(NREQ-1){1'b0}}, 1'b1} << grant_r;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; a ready pulse beats a simultaneous timeout expiry.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (pick_any_s) state_s = ST_ISSUE;
                else            state_s = ST_IDLE;
            end
            ST_ISSUE: begin
                if (unit_ready) state_s = ST_RESP;
                else            state_s = ST_WAIT;
            end
            ST_WAIT: begin
                if (unit_ready)    state_s = ST_RESP;
                else if (expire_s) state_s = ST_RESP;
                else               state_s = ST_WAIT;
            end
            ST_RESP: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // Datapath: grant/operand latch, wait counter and result capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_r  <= GW'(NREQ - 1);
            grant_r   <= '0;
            cnt_r     <= '0;
            a_r       <= '0;
            b_r       <= '0;
            result_r  <= '0;
            timeout_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (pick_any_s) begin
                        grant_r  <= pick_id_s;
                        rr_ptr_r <= pick_id_s;
                        a_r      <= req_a[int'(pick_id_s)*OP_W +: OP_W];
                        b_r      <= req_b[int'(pick_id_s)*OP_W +: OP_W];
                    end else begin
                        grant_r  <= grant_r;
                    end
                end
                ST_ISSUE: begin
                    cnt_r <= '0;
                    if (unit_ready) begin
                        result_r  <= unit_result;
                        timeout_r <= 1'b0;
                    end else begin
                        timeout_r <= timeout_r;
                    end
                end
                ST_WAIT: begin
                    cnt_r <= cnt_r + CNT_W'(1);
                    if (unit_ready) begin
                        result_r  <= unit_result;
                        timeout_r <= 1'b0;
                    end else if (expire_s) begin
                        result_r  <= '0;
                        timeout_r <= 1'b1;
                    end else begin
                        timeout_r <= timeout_r;
                    end
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

    // Output decode from state; pulses are one cycle because the states are.
    always_comb begin
        req_accept  = '0;
        rsp_valid   = '0;
        unit_valid  = 1'b0;
        rsp_timeout = 1'b0;
        busy        = (state_r != ST_IDLE);
        case (state_r)
            ST_ISSUE: begin
                req_accept = grant_oh_s;
                unit_valid = 1'b1;
            end
            ST_RESP: begin
                rsp_valid   = grant_oh_s;
                rsp_timeout = timeout_r;
            end
            default: begin
                req_accept = '0;
            end
        endcase
    end

    assign unit_a     = a_r;
    assign unit_b     = b_r;
    assign rsp_result = result_r;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed testbench for bus_arbiter: inputs change and outputs are checked
// on the falling clock edge; the shared unit is a multiplier driven by hand.
module tb_bus_arbiter;

    localparam int NREQ = 4;
    localparam int TO   = 64;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [3:0]    req_valid;
    logic [63:0]   req_a;
    logic [63:0]   req_b;
    logic [3:0]    req_accept;
    logic [3:0]    rsp_valid;
    logic [31:0]   rsp_result;
    logic          rsp_timeout;
    logic [15:0]   unit_a;
    logic [15:0]   unit_b;
    logic          unit_valid;
    logic          unit_ready;
    logic [31:0]   unit_result;
    logic          busy;

    int vectors = 0;
    int errors  = 0;

    bus_arbiter #(.NREQ(NREQ), .TIMEOUT(TO), .CNT_W(7)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_accept  (req_accept),
        .rsp_valid   (rsp_valid),
        .rsp_result  (rsp_result),
        .rsp_timeout (rsp_timeout),
        .unit_a      (unit_a),
        .unit_b      (unit_b),
        .unit_valid  (unit_valid),
        .unit_ready  (unit_ready),
        .unit_result (unit_result),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One transaction: request, ISSUE checks, unit answers after lat cycles
    // with a*b, RESP checks, then the IDLE cycle.
    task automatic txn(input logic [3:0] req, input logic hold, input int gnt,
                       input logic [15:0] a_exp, input logic [15:0] b_exp,
                       input int lat, input logic [31:0] res_exp, input string tag);
        logic [3:0] oh;
        oh = 4'b0001 << gnt;
        req_valid = req;
        @(negedge clk);
        chk({tag, ".accept"}, 32'(req_accept), 32'(oh));
        chk({tag, ".uvalid"}, 32'(unit_valid), 32'd1);
        chk({tag, ".unit_a"}, 32'(unit_a), 32'(a_exp));
        chk({tag, ".unit_b"}, 32'(unit_b), 32'(b_exp));
        if (!hold) req_valid = 4'b0000;
        if (lat > 0) begin
            repeat (lat) @(negedge clk);
            chk({tag, ".uvalid_lo"}, 32'(unit_valid), 32'd0);
            chk({tag, ".early_rsp"}, 32'(rsp_valid), 32'd0);
        end
        unit_ready  = 1'b1;
        unit_result = 32'(unit_a) * 32'(unit_b);
        @(negedge clk);
        unit_ready  = 1'b0;
        chk({tag, ".rsp_valid"}, 32'(rsp_valid), 32'(oh));
        chk({tag, ".result"}, rsp_result, res_exp);
        chk({tag, ".timeout"}, 32'(rsp_timeout), 32'd0);
        @(negedge clk);
        chk({tag, ".idle"}, 32'(busy), 32'd0);
        chk({tag, ".hold"}, rsp_result, res_exp);
    endtask

    initial begin
        rst_n       = 1'b0;
        req_valid   = 4'b0000;
        req_a       = 64'd0;
        req_b       = 64'd0;
        unit_ready  = 1'b0;
        unit_result = 32'd0;
        repeat (2) @(negedge clk);
        chk("rst.busy",   32'(busy), 32'd0);
        chk("rst.accept", 32'(req_accept), 32'd0);
        chk("rst.rsp",    32'(rsp_valid), 32'd0);
        chk("rst.uvalid", 32'(unit_valid), 32'd0);
        chk("rst.result", rsp_result, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Round-robin with all four requesting continuously.
        req_a = {16'd4, 16'd3, 16'd2, 16'd1};
        req_b = {16'd10, 16'd10, 16'd10, 16'd10};
        txn(4'b1111, 1'b1, 0, 16'd1, 16'd10, 1, 32'd10, "rr0");
        txn(4'b1111, 1'b1, 1, 16'd2, 16'd10, 1, 32'd20, "rr1");
        txn(4'b1111, 1'b1, 2, 16'd3, 16'd10, 1, 32'd30, "rr2");
        txn(4'b1111, 1'b1, 3, 16'd4, 16'd10, 1, 32'd40, "rr3");
        txn(4'b1111, 1'b1, 0, 16'd1, 16'd10, 1, 32'd10, "rr4");
        req_valid = 4'b0000;
        @(negedge clk);

        // Single request, unit latency 2.
        req_a[15:0] = 16'd25;
        req_b[15:0] = 16'd25;
        txn(4'b0001, 1'b0, 0, 16'd25, 16'd25, 2, 32'd625, "single");

        // Zero-latency unit on requester 2.
        req_a[47:32] = 16'd3;
        req_b[47:32] = 16'd7;
        txn(4'b0100, 1'b0, 2, 16'd3, 16'd7, 0, 32'd21, "zero");

        // Timeout on requester 1: unit never answers.
        req_a[31:16] = 16'd9;
        req_b[31:16] = 16'd9;
        unit_result  = 32'hDEADBEEF;
        req_valid    = 4'b0010;
        @(negedge clk);
        chk("to.accept", 32'(req_accept), 32'h2);
        req_valid = 4'b0000;
        repeat (TO) @(negedge clk);
        chk("to.wait_rsp", 32'(rsp_valid), 32'd0);
        chk("to.wait_busy", 32'(busy), 32'd1);
        @(negedge clk);
        chk("to.rsp_valid", 32'(rsp_valid), 32'h2);
        chk("to.result", rsp_result, 32'd0);
        chk("to.timeout", 32'(rsp_timeout), 32'd1);
        @(negedge clk);
        chk("to.idle", 32'(busy), 32'd0);
        chk("to.timeout_lo", 32'(rsp_timeout), 32'd0);

        // Normal service after a timeout; pointer at 1 so requester 3 wins.
        req_a[63:48] = 16'd12;
        req_b[63:48] = 16'd12;
        txn(4'b1010, 1'b0, 3, 16'd12, 16'd12, 3, 32'd144, "after_to");

        // Ready arriving on the last count beats the timeout.
        req_a[15:0] = 16'd5;
        req_b[15:0] = 16'd6;
        txn(4'b0001, 1'b0, 0, 16'd5, 16'd6, TO, 32'd30, "ready_vs_to");

        // Reset in WAIT, then a late ready pulse that must be ignored.
        req_a[47:32] = 16'd8;
        req_valid    = 4'b0100;
        @(negedge clk);
        chk("mid.accept", 32'(req_accept), 32'h4);
        req_valid = 4'b0000;
        @(negedge clk);
        chk("mid.busy", 32'(busy), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid.rst_busy", 32'(busy), 32'd0);
        chk("mid.rst_rsp", 32'(rsp_valid), 32'd0);
        chk("mid.rst_result", rsp_result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        unit_ready  = 1'b1;
        unit_result = 32'd99;
        @(negedge clk);
        unit_ready = 1'b0;
        chk("mid.late_rsp", 32'(rsp_valid), 32'd0);
        chk("mid.late_busy", 32'(busy), 32'd0);
        @(negedge clk);
        chk("mid.late_rsp2", 32'(rsp_valid), 32'd0);

        // Pointer restored by reset: requester 0 wins first.
        txn(4'b1111, 1'b0, 0, 16'd5, 16'd6, 1, 32'd30, "post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
